// File: rtl/sweep_ray_painter.sv
// Sweep ray painter: walks one ray of range samples from a fixed origin using
// per-angle cos/sin increments and writes on-screen samples into the frame RAM.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | wait for FIFO data (or erase), clip test, capture addr/data
// ISSUE   | ram_we held until ram_ready
// ADVANCE | pop sample, step accumulators, bump index
// DONE    | one-cycle done pulse
module sweep_ray_painter #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int DATA_W  = 3,
  parameter int RANGE_W = 10,
  parameter int TRIG_W  = 12,
  parameter int FRAC    = 10,
  parameter int ORG_X   = H_RES / 2,
  parameter int ORG_Y   = V_RES - 1,
  parameter int ADDR_W  = 19
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic signed [TRIG_W-1:0]  cos_in,
  input  logic signed [TRIG_W-1:0]  sin_in,
  input  logic [RANGE_W-1:0]        n_samples,
  input  logic                      erase,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  input  logic [DATA_W-1:0]         fifo_q,
  input  logic                      fifo_empty,
  output logic                      fifo_rd,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_data,
  output logic                      ram_we,
  input  logic                      ram_ready
);

  localparam int ACC_W = RANGE_W + TRIG_W + 2;
  localparam int PX_W  = ACC_W - FRAC;

  localparam logic signed [ACC_W-1:0] X_ORG = ACC_W'(ORG_X) << FRAC;
  localparam logic signed [ACC_W-1:0] Y_ORG = ACC_W'(ORG_Y) << FRAC;
  localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1) << (FRAC - 1);
  localparam logic signed [PX_W-1:0]  H_LIM = PX_W'(H_RES);
  localparam logic signed [PX_W-1:0]  V_LIM = PX_W'(V_RES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_ADVANCE,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic signed [ACC_W-1:0]  x_acc, y_acc;
  logic signed [TRIG_W-1:0] cos_q, sin_q;
  logic [RANGE_W-1:0]       n_q, r_idx;
  logic                     erase_q;

  logic signed [ACC_W-1:0]  x_rnd, y_rnd;
  logic signed [PX_W-1:0]   px, py;
  logic                     on_screen;
  logic [ADDR_W-1:0]        addr_calc;
  logic signed [ACC_W-1:0]  cos_ext, sin_ext;

  logic load, capture, step;

  // Round half up, then arithmetic shift down to integer pixels.
  always_comb begin
    x_rnd     = x_acc + HALF;
    y_rnd     = y_acc + HALF;
    px        = x_rnd[ACC_W-1:FRAC];
    py        = y_rnd[ACC_W-1:FRAC];
    on_screen = !px[PX_W-1] && (px < H_LIM) && !py[PX_W-1] && (py < V_LIM);
    addr_calc = ADDR_W'($unsigned(py)) * ADDR_W'(H_RES) + ADDR_W'($unsigned(px));
    cos_ext   = {{(ACC_W-TRIG_W){cos_q[TRIG_W-1]}}, cos_q};
    sin_ext   = {{(ACC_W-TRIG_W){sin_q[TRIG_W-1]}}, sin_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    step      = 1'b0;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    ram_we    = (state == S_ISSUE) && !abort;
    fifo_rd   = (state == S_ADVANCE) && !erase_q && !abort;
    case (state)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = (n_samples == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (erase_q || !fifo_empty) begin
          if (on_screen) begin
            capture   = 1'b1;
            state_nxt = S_ISSUE;
          end else begin
            state_nxt = S_ADVANCE;
          end
        end
      end
      S_ISSUE: begin
        if (ram_ready) state_nxt = S_ADVANCE;
      end
      S_ADVANCE: begin
        step      = 1'b1;
        state_nxt = (r_idx == n_q - RANGE_W'(1)) ? S_DONE : S_FETCH;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // abort wins over everything, including a same-cycle ram_ready
    if (abort) begin
      state_nxt = S_IDLE;
      load      = 1'b0;
      capture   = 1'b0;
      step      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_acc    <= '0;
      y_acc    <= '0;
      cos_q    <= '0;
      sin_q    <= '0;
      n_q      <= '0;
      r_idx    <= '0;
      erase_q  <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
    end else begin
      if (load) begin
        cos_q   <= cos_in;
        sin_q   <= sin_in;
        n_q     <= n_samples;
        erase_q <= erase;
        r_idx   <= '0;
        x_acc   <= X_ORG;
        y_acc   <= Y_ORG;
      end
      if (capture) begin
        ram_addr <= addr_calc;
        ram_data <= erase_q ? '0 : fifo_q;
      end
      // screen y grows downward, so positive sin moves the ray up
      if (step) begin
        x_acc <= x_acc + cos_ext;
        y_acc <= y_acc - sin_ext;
        r_idx <= r_idx + RANGE_W'(1);
      end
    end
  end

endmodule
